// File: rtl/seeg_spi_responder.sv
// SPI mode-0 responder for one SEEG front-end port; responses lag commands by two frames.
// Optional SEEG_RESP_MONITOR_EN adds frame_valid/frame_cmd observation outputs.
module seeg_spi_responder #(
    parameter int          NUM_REGS = 16,
    parameter logic [15:0] CHIP_ID  = 16'h0020
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        cs_n,
    input  logic        sclk,
    input  logic        mosi,
    output logic        miso
`ifdef SEEG_RESP_MONITOR_EN
    ,
    output logic        frame_valid,
    output logic [31:0] frame_cmd
`endif
);

    localparam int         AW     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [8:0] NREGS9 = 9'(NUM_REGS);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // [0],[1] synchronizer flops, [2] previous synchronized value
    logic [2:0] cs_q;
    logic [2:0] sclk_q;
    logic [1:0] mosi_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cs_q   <= 3'b111;
            sclk_q <= 3'b000;
            mosi_q <= 2'b00;
        end else begin
            cs_q   <= {cs_q[1:0], cs_n};
            sclk_q <= {sclk_q[1:0], sclk};
            mosi_q <= {mosi_q[0], mosi};
        end
    end

    logic cs_rise, cs_fall, sclk_rise, sclk_fall, mosi_s;

    assign cs_rise   =  cs_q[1] & ~cs_q[2];
    assign cs_fall   = ~cs_q[1] &  cs_q[2];
    assign sclk_rise =  sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] &  sclk_q[2];
    assign mosi_s    =  mosi_q[1];

    logic [1:0]  state;
    logic [5:0]  bit_cnt;
    logic [31:0] rx_shift;
    logic [31:0] tx_shift;
    logic [31:0] pipe0;
    logic [31:0] pipe1;
    logic [15:0] conv_cnt;
    logic [15:0] regs [NUM_REGS];

    logic [31:0] cmd;
    logic [1:0]  op;
    logic [7:0]  addr;
    logic [15:0] data;
    logic [5:0]  chan;
    logic        addr_ok;
    logic [15:0] rd_val;
    logic [31:0] result;
    logic        exec;

    assign cmd = {rx_shift[30:0], mosi_s};

    // cs_n edges take priority over any sclk edge seen in the same cycle
    assign exec = (state == S_SHIFT) && sclk_rise && !cs_rise && !cs_fall
                  && (bit_cnt == 6'd31);

    always_comb begin
        op      = cmd[31:30];
        addr    = cmd[23:16];
        data    = cmd[15:0];
        chan    = cmd[21:16];
        addr_ok = ({1'b0, addr} < NREGS9);
        rd_val  = 16'h0000;
        if (addr == 8'hFF)
            rd_val = CHIP_ID;
        else if (addr_ok)
            rd_val = regs[addr[AW-1:0]];
        result = 32'h0;
        unique case (op)
            2'b00: result = {10'b0, chan, conv_cnt};
            2'b01: result = 32'h0;
            2'b10: result = {16'hFFFF, data};
            2'b11: result = {16'h0000, rd_val};
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= S_IDLE;
            bit_cnt  <= 6'd0;
            rx_shift <= 32'h0;
            tx_shift <= 32'h0;
            pipe0    <= 32'h0;
            pipe1    <= 32'h0;
            miso     <= 1'b0;
        end else if (cs_rise) begin
            state <= S_IDLE;
            miso  <= 1'b0;
        end else if (cs_fall) begin
            state    <= S_SHIFT;
            bit_cnt  <= 6'd0;
            tx_shift <= pipe1;
            miso     <= pipe1[31];
        end else if (state == S_SHIFT) begin
            if (sclk_rise) begin
                rx_shift <= cmd;
                bit_cnt  <= bit_cnt + 6'd1;
                if (exec) begin
                    pipe1 <= pipe0;
                    pipe0 <= result;
                    state <= S_DONE;
                end
            end else if (sclk_fall) begin
                tx_shift <= {tx_shift[30:0], 1'b0};
                miso     <= tx_shift[30];
            end
        end else if (state == S_DONE) begin
            if (sclk_fall) begin
                tx_shift <= 32'h0;
                miso     <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            conv_cnt <= 16'h0;
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= 16'h0;
        end else if (exec) begin
            if (op == 2'b00)
                conv_cnt <= conv_cnt + 16'h1;
            else if (op == 2'b01)
                conv_cnt <= 16'h0;
            if (op == 2'b10 && addr_ok)
                regs[addr[AW-1:0]] <= data;
        end
    end

`ifdef SEEG_RESP_MONITOR_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frame_valid <= 1'b0;
            frame_cmd   <= 32'h0;
        end else begin
            frame_valid <= exec;
            if (exec)
                frame_cmd <= cmd;
        end
    end
`endif

    logic unused_bits;
    assign unused_bits = ^{rx_shift[31], cmd[29:24]};

endmodule

// File: tb/tb_seeg_spi_responder.sv
// Bench for seeg_spi_responder: table of SPI frames, expected responses
// queued per frame and compared two frames later against the MISO word.
module tb_seeg_spi_responder;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic cs_n = 1'b1;
    logic sclk = 1'b0;
    logic mosi = 1'b0;
    logic miso;

`ifdef SEEG_RESP_MONITOR_EN
    logic        frame_valid;
    logic [31:0] frame_cmd;
`endif

    seeg_spi_responder dut (
        .clk  (clk),
        .rstn (rstn),
        .cs_n (cs_n),
        .sclk (sclk),
        .mosi (mosi),
        .miso (miso)
`ifdef SEEG_RESP_MONITOR_EN
        ,
        .frame_valid (frame_valid),
        .frame_cmd   (frame_cmd)
`endif
    );

    always #5 clk = ~clk;

    localparam int A_NONE   = 0;
    localparam int A_RST    = 1;
    localparam int A_ABORT  = 2;
    localparam int A_MIDRST = 3;

    typedef struct {
        int          act;
        logic [31:0] cmd;
        logic [31:0] res;
    } vec_t;

    vec_t        tab[$];
    logic [31:0] sb[$];
    int          n_vec = 0;
    int          n_bad = 0;

    function automatic void add(input int a, input logic [31:0] c,
                                input logic [31:0] r);
        vec_t v;
        v.act = a;
        v.cmd = c;
        v.res = r;
        tab.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", name, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        cs_n = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        wait_clk(4);
        check("reset_miso", {31'b0, miso}, 32'h0);
        rstn = 1'b1;
        wait_clk(4);
        sb.delete();
        sb.push_back(32'h0);
        sb.push_back(32'h0);
    endtask

    // Drives nbits of cmd; rst_mid pulses rstn instead of a normal end
    task automatic frame(input logic [31:0] cmd, input int nbits,
                         input bit rst_mid, output logic [31:0] rsp);
        rsp  = 32'h0;
        cs_n = 1'b0;
        wait_clk(4);
        for (int i = 0; i < 32; i++) begin
            if (i == nbits)
                break;
            mosi = cmd[31-i];
            wait_clk(4);
            rsp  = {rsp[30:0], miso};
            sclk = 1'b1;
            wait_clk(4);
            sclk = 1'b0;
        end
        if (rst_mid) begin
            rstn = 1'b0;
            #1;
            check("midrst_miso", {31'b0, miso}, 32'h0);
            @(negedge clk);
            cs_n = 1'b1;
            mosi = 1'b0;
            wait_clk(3);
            rstn = 1'b1;
            wait_clk(6);
            sb.delete();
            sb.push_back(32'h0);
            sb.push_back(32'h0);
        end else begin
            wait_clk(4);
            cs_n = 1'b1;
            mosi = 1'b0;
            wait_clk(6);
        end
    endtask

    initial begin
        logic [31:0] rsp;
        logic [31:0] exp;
        string       nm;

        add(A_RST,    32'h8003_BEEF, 32'hFFFF_BEEF);
        add(A_NONE,   32'hC003_0000, 32'h0000_BEEF);
        add(A_NONE,   32'h0000_0000, 32'h0000_0000);
        add(A_NONE,   32'h0000_0000, 32'h0000_0001);

        add(A_RST,    32'h0005_0000, 32'h0005_0000);
        add(A_NONE,   32'h0005_0000, 32'h0005_0001);
        add(A_NONE,   32'h0005_0000, 32'h0005_0002);
        add(A_NONE,   32'h0005_0000, 32'h0005_0003);
        add(A_NONE,   32'h4000_0000, 32'h0000_0000);
        add(A_NONE,   32'h003F_0000, 32'h003F_0000);
        add(A_NONE,   32'h003F_0000, 32'h003F_0001);
        add(A_NONE,   32'h003F_0000, 32'h003F_0002);
        add(A_ABORT,  32'h8001_1234, 32'h0000_0000);
        add(A_NONE,   32'hC001_0000, 32'h0000_0000);
        add(A_NONE,   32'hC0FF_0000, 32'h0000_0020);
        add(A_NONE,   32'hC0C8_0000, 32'h0000_0000);
        add(A_NONE,   32'h80C8_5A5A, 32'hFFFF_5A5A);
        add(A_NONE,   32'hC0C8_0000, 32'h0000_0000);
        add(A_NONE,   32'h800F_A5A5, 32'hFFFF_A5A5);
        add(A_NONE,   32'hC00F_0000, 32'h0000_A5A5);
        add(A_NONE,   32'hC010_0000, 32'h0000_0000);
        add(A_NONE,   32'h0001_0000, 32'h0001_0003);
        add(A_NONE,   32'hC0FF_0000, 32'h0000_0020);
        add(A_NONE,   32'hC0FF_0000, 32'h0000_0020);

        add(A_MIDRST, 32'hC00F_0000, 32'h0000_0000);
        add(A_NONE,   32'h0005_0000, 32'h0005_0000);
        add(A_NONE,   32'h0005_0000, 32'h0005_0001);
        add(A_NONE,   32'hC00F_0000, 32'h0000_0000);
        add(A_NONE,   32'hC0FF_0000, 32'h0000_0020);
        add(A_NONE,   32'hC0FF_0000, 32'h0000_0020);

        do_reset();

        foreach (tab[i]) begin
            if (tab[i].act == A_RST)
                do_reset();
            case (tab[i].act)
                A_ABORT:  frame(tab[i].cmd, 20, 1'b0, rsp);
                A_MIDRST: frame(tab[i].cmd, 16, 1'b1, rsp);
                default: begin
                    frame(tab[i].cmd, 32, 1'b0, rsp);
                    nm = $sformatf("frame%0d_cmd%08h", i, tab[i].cmd);
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL %s: scoreboard empty, got %08h", nm, rsp);
                    end else begin
                        exp = sb.pop_front();
                        check(nm, rsp, exp);
                    end
                    sb.push_back(tab[i].res);
                end
            endcase
            check($sformatf("idle_miso%0d", i), {31'b0, miso}, 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
